axi_ifu_slave: RTL and testbench
================================

// Module: axi_ifu_slave
// PURPOSE
//  Read-only AXI-lite responder serving the instruction-fetch master: accepts one AR request,
//  reads a 64-bit doubleword from a synchronous instruction memory port, returns it on R.
//  Sits between the IFU read master and instruction memory; one outstanding transaction at a time.
// PARAMETERS
//  ADDR_W       64              address width (matches PC width)
//  DATA_W       64              data width
//  MEM_BASE     64'h8000_0000   first valid byte address
//  MEM_SIZE     64'h0800_0000   valid window size in bytes (multiple of 8)
//  RD_LATENCY   1               cycles from mem_en pulse to mem_rdata valid (>=1)
//  WAIT_CYCLES  0               extra stall cycles before r_valid (0..15, models slow memory)
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous active-high reset
//  ifu_ar_addr   in   ADDR_W  read address
//  ifu_ar_valid  in   1       read address valid
//  ifu_ar_ready  out  1       read address ready
//  ifu_r_data    out  DATA_W  read data
//  ifu_r_resp    out  2       2'b00 OKAY, 2'b10 SLVERR
//  ifu_r_valid   out  1       read data valid
//  ifu_r_ready   in   1       read data ready
//  mem_en        out  1       one-cycle memory read strobe
//  mem_addr      out  ADDR_W  memory address, low 3 bits always 0
//  mem_rdata     in   DATA_W  memory data, valid RD_LATENCY cycles after mem_en
// BEHAVIOUR
//  - Clock clk, reset rst: synchronous, active-high; all outputs registered.
//  - Reset values: ifu_ar_ready=1, ifu_r_valid=0, ifu_r_data=0, ifu_r_resp=0, mem_en=0, mem_addr=0; state IDLE.
//  - FSM: IDLE -> READ -> WAIT -> RESP -> IDLE.
//  - IDLE: ar_ready=1. On ar_valid&ar_ready (cycle T): latch addr, ar_ready=0 from T+1.
//    Legal (addr[1:0]==0, MEM_BASE<=addr<=MEM_BASE+MEM_SIZE-8, compared at ADDR_W+1 bits, no wrap) -> READ.
//    Illegal -> RESP directly: r_valid=1 at T+1, r_resp=2'b10, r_data=0, no mem_en issued.
//  - READ: mem_en=1 for exactly one cycle (T+1), mem_addr={addr[ADDR_W-1:3],3'b0}.
//    Counter captures mem_rdata at RD_LATENCY cycles after the strobe.
//  - WAIT: count WAIT_CYCLES (skipped when 0). Legal read: r_valid rises at T+1+RD_LATENCY+WAIT_CYCLES
//    (defaults: T+2), r_resp=2'b00.
//  - RESP: r_valid, r_data, r_resp held stable until r_valid&r_ready; then r_valid=0 and
//    ar_ready=1 next cycle (IDLE). No AR accepted outside IDLE.
//    Min spacing: 3 cycles per legal fetch at defaults with r_ready tied 1.
//  - r_ready high before r_valid has no effect.
//  - ar_valid deasserted before handshake: no transaction.
//  - r_data is never updated while r_valid=1.
//  - Reset mid-transaction: FSM to IDLE; pending mem_rdata discarded; no r_valid produced for the
//    aborted request.
//  - ar_addr changes after handshake: ignored (latched copy used).
// TESTING
//  1. Default params, r_ready=1, ar_valid pulse addr=0x8000_0004, mem returns 0x0000_0013_0000_0093
//     -> mem_en at T+1, mem_addr=0x8000_0000; r_valid at T+2, data=0x0000_0013_0000_0093, resp=00.
//  2. addr=0x7FFF_FFF8 and addr=0x8800_0000 -> r_valid at T+1, resp=2'b10, data=0, mem_en never asserted.
//  3. addr=0x8000_0002 (misaligned) -> SLVERR at T+1; next legal fetch 0x8000_0008 -> OKAY.
//  4. r_ready held 0 for 5 cycles after r_valid -> r_valid/data/resp stable, ar_ready=0 throughout;
//     ar_ready=1 the cycle after the r_ready handshake.
//  5. RD_LATENCY=3, WAIT_CYCLES=2, addr=0x8000_0010 -> r_valid exactly at T+6 with memory data.
//  6. rst asserted at T+1 of a legal fetch -> outputs at reset values next cycle; no r_valid;
//     ar_ready=1 and a new fetch 0x8000_0000 completes normally.

Source files
------------

// File: rtl/axi_ifu_slave.sv
// Read-only AXI-lite responder for the instruction-fetch unit.
// Accepts one AR at a time, reads one doubleword from synchronous instruction memory, returns it on R.
module axi_ifu_slave #(
  parameter int                ADDR_W      = 64,
  parameter int                DATA_W      = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE    = 'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE    = 'h0800_0000,
  parameter int                RD_LATENCY  = 1,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_ar_addr,
  input  logic              ifu_ar_valid,
  output logic              ifu_ar_ready,
  output logic [DATA_W-1:0] ifu_r_data,
  output logic [1:0]        ifu_r_resp,
  output logic              ifu_r_valid,
  input  logic              ifu_r_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state  | meaning
  // S_IDLE | ar_ready high, waiting for a fetch request
  // S_READ | strobe issued, counting down to the memory capture edge
  // S_WAIT | data captured, inserting slow-memory stall cycles
  // S_RESP | r_valid high, holding R until the master takes it

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_RESP} state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAT_INIT  = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One extra bit so base+size never wraps around the top of the address space
  localparam logic [ADDR_W:0] EIGHT   = (ADDR_W+1)'(8);
  localparam logic [ADDR_W:0] ADDR_LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_W:0] ADDR_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - EIGHT;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ar_ready_q, ar_ready_d;
  logic               r_valid_q, r_valid_d;
  logic [DATA_W-1:0]  r_data_q, r_data_d;
  logic [1:0]         r_resp_q, r_resp_d;
  logic               mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]    addr_x;
  logic               addr_legal;

  always_comb begin
    addr_x     = {1'b0, ifu_ar_addr};
    addr_legal = (ifu_ar_addr[1:0] == 2'b00) && (addr_x >= ADDR_LO) && (addr_x <= ADDR_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_ar_valid && ar_ready_q) begin
          ar_ready_d = 1'b0;
          if (addr_legal) begin
            state_d    = S_READ;
            mem_en_d   = 1'b1;
            mem_addr_d = {ifu_ar_addr[ADDR_W-1:3], 3'b000};
            cnt_d      = LAT_INIT;
          end else begin
            state_d   = S_RESP;
            r_valid_d = 1'b1;
            r_resp_d  = RESP_SLVERR;
            r_data_d  = '0;
          end
        end
      end
      S_READ: begin
        // r_valid is low here, so loading r_data early cannot disturb a visible response
        if (cnt_q == '0) begin
          r_data_d = mem_rdata;
          r_resp_d = RESP_OKAY;
          if (WAIT_CYCLES == 0) begin
            r_valid_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          r_valid_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (ifu_r_ready) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ifu_ar_ready = ar_ready_q;
  assign ifu_r_valid  = r_valid_q;
  assign ifu_r_data   = r_data_q;
  assign ifu_r_resp   = r_resp_q;
  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_axi_ifu_slave.sv
// Bench for axi_ifu_slave: default instance plus a slow-memory instance (RD_LATENCY=3, WAIT_CYCLES=2),
// directed fetches followed by randomized fetches checked against a transaction-level model.
module tb_axi_ifu_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic [63:0] ar_addr   [2];
  logic        ar_valid  [2];
  logic        ar_ready  [2];
  logic [63:0] r_data    [2];
  logic [1:0]  r_resp    [2];
  logic        r_valid   [2];
  logic        r_ready   [2];
  logic        mem_en    [2];
  logic [63:0] mem_addr  [2];
  logic [63:0] mem_rdata [2];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int          men_cnt  [2];
  int          men_cyc  [2];
  logic [63:0] men_addr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_ifu_slave u_dut (
    .clk(clk), .rst(rst[0]),
    .ifu_ar_addr(ar_addr[0]), .ifu_ar_valid(ar_valid[0]), .ifu_ar_ready(ar_ready[0]),
    .ifu_r_data(r_data[0]), .ifu_r_resp(r_resp[0]), .ifu_r_valid(r_valid[0]), .ifu_r_ready(r_ready[0]),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0])
  );

  axi_ifu_slave #(.RD_LATENCY(3), .WAIT_CYCLES(2)) u_dut_slow (
    .clk(clk), .rst(rst[1]),
    .ifu_ar_addr(ar_addr[1]), .ifu_ar_valid(ar_valid[1]), .ifu_ar_ready(ar_ready[1]),
    .ifu_r_data(r_data[1]), .ifu_r_resp(r_resp[1]), .ifu_r_valid(r_valid[1]), .ifu_r_ready(r_ready[1]),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic int rdl(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int wcy(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == BASE) return 64'h0000_0013_0000_0093;
    return {a[31:0] ^ 32'h1357_9BDF, ~a[31:0]};
  endfunction

  // Memory model: data is valid only at the capture edge RD_LATENCY edges after mem_en launched,
  // junk otherwise, so an early or late capture is visible.
  logic        st_v [1:2];
  logic [63:0] st_a [1:2];
  always @(posedge clk) begin
    st_v[1] <= mem_en[1];
    st_a[1] <= mem_addr[1];
    st_v[2] <= st_v[1];
    st_a[2] <= st_a[1];
  end
  assign mem_rdata[0] = (mem_en[0] === 1'b1) ? mem_word(mem_addr[0]) : (64'hBAD0_BAD0_BAD0_BAD0 ^ 64'(cyc));
  assign mem_rdata[1] = (st_v[2] === 1'b1) ? mem_word(st_a[2]) : (64'hBAD1_BAD1_BAD1_BAD1 ^ 64'(cyc));

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] === 1'b1) begin
        men_cnt[k]  = men_cnt[k] + 1;
        men_cyc[k]  = cyc;
        men_addr[k] = mem_addr[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_ar_ready", ar_ready[k], 1);
    chk("rst_r_valid", r_valid[k], 0);
    chk("rst_r_data", r_data[k], 0);
    chk("rst_r_resp", r_resp[k], 0);
    chk("rst_mem_en", mem_en[k], 0);
    chk("rst_mem_addr", mem_addr[k], 0);
  endtask

  // One complete fetch starting at a negedge with the slave idle; returns at a negedge with it idle again.
  task automatic fetch(input int k, input logic [63:0] addr, input int hold);
    bit          legal;
    int          t, lat, n0;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    legal = (addr[1:0] == 2'b00) && (addr >= BASE) && (addr <= BASE + SIZE - 64'd8);
    lat   = legal ? 1 + rdl(k) + wcy(k) : 1;
    exp_d = legal ? mem_word({addr[63:3], 3'b000}) : 64'd0;
    exp_r = legal ? 2'b00 : 2'b10;
    n0    = men_cnt[k];
    chk("ar_ready_idle", ar_ready[k], 1);
    ar_addr[k]  = addr;
    ar_valid[k] = 1'b1;
    r_ready[k]  = (hold == 0);
    t = cyc;
    @(negedge clk);
    ar_valid[k] = 1'b0;
    ar_addr[k]  = {$urandom, $urandom};
    chk("ar_ready_busy", ar_ready[k], 0);
    while (r_valid[k] !== 1'b1 && cyc - t < 24) begin
      @(negedge clk);
      if (r_valid[k] !== 1'b1) chk("r_valid_early_ar_ready", ar_ready[k], 0);
    end
    chk("r_valid_rise", r_valid[k], 1);
    if (r_valid[k] !== 1'b1) return;
    chk("latency", 64'(cyc - t), 64'(lat));
    chk("r_data", r_data[k], exp_d);
    chk("r_resp", r_resp[k], exp_r);
    chk("mem_en_count", 64'(men_cnt[k] - n0), legal ? 64'd1 : 64'd0);
    if (legal) begin
      chk("mem_en_cycle", 64'(men_cyc[k] - t), 64'd1);
      chk("mem_addr", men_addr[k], {addr[63:3], 3'b000});
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_r_valid", r_valid[k], 1);
      chk("hold_r_data", r_data[k], exp_d);
      chk("hold_r_resp", r_resp[k], exp_r);
      chk("hold_ar_ready", ar_ready[k], 0);
    end
    r_ready[k] = 1'b1;
    @(negedge clk);
    chk("r_valid_fall", r_valid[k], 0);
    chk("ar_ready_back", ar_ready[k], 1);
    chk("mem_en_total", 64'(men_cnt[k] - n0), legal ? 64'd1 : 64'd0);
    r_ready[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_mid(input int k);
    ar_addr[k]  = BASE + 64'h40;
    ar_valid[k] = 1'b1;
    r_ready[k]  = 1'b1;
    @(negedge clk);
    ar_valid[k] = 1'b0;
    chk("pre_rst_mem_en", mem_en[k], 1);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
    chk_reset_vals(k);
    repeat (8) begin
      @(negedge clk);
      chk("no_r_valid_after_rst", r_valid[k], 0);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 3))
      0: begin
        a = BASE + {37'b0, 24'($urandom_range(0, 32'h00FF_FFFF)), 3'b000};
        if ($urandom_range(0, 1) == 1) a[2] = 1'b1;
      end
      1: begin
        case ($urandom_range(0, 7))
          0: a = BASE - 64'd8;
          1: a = BASE - 64'd4;
          2: a = BASE;
          3: a = BASE + SIZE - 64'd8;
          4: a = BASE + SIZE - 64'd4;
          5: a = BASE + SIZE;
          6: a = 64'hFFFF_FFFF_FFFF_FFF8;
          default: a = 64'd0;
        endcase
      end
      2: begin
        a = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
        a[1:0] = 2'($urandom_range(1, 3));
      end
      default: begin
        a = {$urandom, $urandom};
        a[1:0] = 2'b00;
      end
    endcase
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; ar_valid[k] = 1'b0; r_ready[k] = 1'b0; ar_addr[k] = '0;
      men_cnt[k] = 0; men_cyc[k] = 0; men_addr[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) chk_reset_vals(k);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk_reset_vals(k);

    fetch(0, 64'h8000_0004, 0);
    fetch(0, 64'h7FFF_FFF8, 0);
    fetch(0, 64'h8800_0000, 0);
    fetch(0, 64'h8000_0002, 0);
    fetch(0, 64'h8000_0008, 0);
    fetch(0, 64'h8000_0100, 5);
    fetch(1, 64'h8000_0010, 0);
    fetch(1, 64'h87FF_FFFC, 2);
    reset_mid(0);
    fetch(0, BASE, 0);
    reset_mid(1);
    fetch(1, BASE, 1);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        n0 = men_cnt[k];
        repeat ($urandom_range(0, 2)) begin
          ar_addr[k] = rand_addr();
          @(negedge clk);
          chk("gap_r_valid", r_valid[k], 0);
        end
        chk("gap_mem_en", 64'(men_cnt[k] - n0), 64'd0);
        fetch(k, rand_addr(), $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
